// File: rtl/multiword_adder_seq.sv
// Sequential wide adder: one N-bit slice reused over WORDS cycles, carry held between slices; start/busy/done handshake.
// Optional OVERFLOW_FLAG_EN adds a registered two's-complement overflow output (ovf) updated with sum/c_out.
module multiword_adder_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4,
  localparam int W    = N * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         c_in,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         c_out
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic         ovf
`endif
);

  localparam int CNT_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]     xr_q, xr_d;
  logic [W-1:0]     yr_q, yr_d;
  logic [W-1:0]     res_q, res_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  logic             accept;
  logic             last_slice;
  logic [N:0]       slice_full;
  logic [W-1:0]     res_next;
  logic             msb_cin;

  // Operands are accepted from IDLE or DONE, which gives back-to-back issue.
  assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_slice = (cnt_q == CNT_W'(WORDS - 1));

  assign slice_full = {1'b0, xr_q[N-1:0]} + {1'b0, yr_q[N-1:0]} + {{N{1'b0}}, carry_q};
  assign res_next   = {slice_full[N-1:0], res_q[W-1:N]};
  // Carry into the slice MSB recovered from the MSB sum bit and its two addend bits.
  assign msb_cin    = slice_full[N-1] ^ xr_q[N-1] ^ yr_q[N-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_comb begin
    xr_d    = xr_q;
    yr_d    = yr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      xr_d    = x;
      yr_d    = y;
      carry_d = c_in;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == RUN) begin
      xr_d    = xr_q >> N;
      yr_d    = yr_q >> N;
      carry_d = slice_full[N];
      res_d   = res_next;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_slice) begin
        sum_d   = res_next;
        c_out_d = slice_full[N];
`ifdef OVERFLOW_FLAG_EN
        ovf_d   = msb_cin ^ slice_full[N];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr_q    <= '0;
      yr_q    <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
    end else begin
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
    end
  end

`ifdef OVERFLOW_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_msb_cin;
  assign unused_msb_cin = msb_cin;
`endif

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: doc/multiword_adder_seq.md
Name: multiword_adder_seq

Overview:
Sequential multi-word adder that adds two wide operands by reusing one N-bit adder slice over WORDS clock cycles. The carry between slices is held in a register.
- It is the stage directly upstream of the team's N-bit adder consumers. It produces a wide sum and carry-out with a start/busy/done handshake, using area-cheap ripple-by-cycle addition.
- The slice adder is inline, using behavioural addition of N+1 bits.

Parameters:
N, 4, width of the adder slice in bits (N >= 1)
WORDS, 4, number of slices per operation (WORDS >= 2); total width W = N*WORDS (default 16)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
x  input  W  operand A, sampled only when start is accepted
y  input  W  operand B, sampled only when start is accepted
c_in  input  1  carry-in into slice 0, sampled with x/y
start  input  1  request; accepted in IDLE or DONE state
busy  output  1  high while an operation is in progress (RUN)
done  output  1  one-cycle pulse: sum/c_out just updated
sum  output  W  result, registered, holds last completed value
c_out  output  1  carry-out of MSB slice, registered with sum

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is asynchronous and active-high.
  - While rst=1: state=IDLE, busy=0, done=0, sum=0, c_out=0, slice counter=0, carry register=0, operand registers=0.
- FSM states are IDLE, RUN and DONE.
  - IDLE: busy=0, done=0. If start=1 at an edge (E0): latch x, y and c_in into internal registers, clear the counter, go to RUN.
  - RUN: busy=1. Each edge computes one slice: {carry, slice} = xr[N-1:0] + yr[N-1:0] + carry.
    - The slice is shifted into the internal result register from the MSB end.
    - xr and yr shift right by N.
    - The counter increments.
    - On the edge that computes slice WORDS-1 (E_WORDS): load sum from the completed result, load c_out from the final carry, go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - Next edge: if start=1, accept the new operation as in IDLE (back-to-back, no idle cycle needed).
    - Otherwise go to IDLE.
- Latency:
  - start sampled at E0 means busy=1 after E0, and done=1 in the cycle after E_WORDS.
  - That gives WORDS cycles from start acceptance to done (4 cycles at default).
  - Throughput is one operation per WORDS+1 cycles.
- Output stability: sum and c_out change only on the RUN->DONE edge. Intermediate slice results are never visible on sum.
- start during RUN is ignored. It is not queued, and the operands in flight are unaffected.
- x/y/c_in changing after acceptance do not affect the in-flight result.
- Arithmetic: result is exactly (x + y + c_in) mod 2^W; c_out = bit W of the full sum. Unsigned, no saturation.
- Reset mid-operation aborts immediately: all state and outputs return to reset values, and no done pulse is produced.

Optional Feature:
OVERFLOW_FLAG_EN
- Defined:
  - Adds output port ovf (1 bit), registered and updated together with sum/c_out.
  - ovf = carry into MSB of slice WORDS-1 XOR carry out of it (two's-complement signed overflow).
  - Reset value is 0; ovf holds its value between operations.
- Not defined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Basic add, defaults: x=16'h1234, y=16'h4321, c_in=0, pulse start -> busy=1 for 4 cycles, then done=1 for 1 cycle, sum=16'h5555, c_out=0.
2. Full carry ripple: x=16'hFFFF, y=16'h0001, c_in=0 -> sum=16'h0000, c_out=1. Also x=16'hFFFF, y=16'hFFFF, c_in=1 -> sum=16'hFFFF, c_out=1. sum keeps its previous value during RUN in both cases.
3. Ignored start/operand change:
   - Run x=16'h0101, y=16'h0202.
   - Assert start and change x to 16'hAAAA during RUN.
   - Required: result sum=16'h0303; exactly one done pulse; FSM returns to IDLE.
4. Back-to-back: hold start=1 through DONE with x=16'h000F, y=16'h0001 -> second operation starts with no IDLE cycle; sum=16'h0010 exactly 5 cycles after the first done.
5. Async reset mid-op: assert rst in the 2nd RUN cycle, between clock edges -> busy, done, sum and c_out go to 0 immediately; no done pulse after release; the next start completes normally.
6. With OVERFLOW_FLAG_EN:
   - x=16'h7FFF, y=16'h0001 -> sum=16'h8000, c_out=0, ovf=1.
   - x=16'hFFFF, y=16'h0001 -> ovf=0, c_out=1.
